// File: rtl/div_pkg.sv
// Shared types and default geometry for the sequential restoring divider.
package div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int CNT_W      = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, subtract the divisor if it fits, and emit the
// resulting quotient bit.
module div_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W:0]   pr,
  input  logic                 dividend_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   pr_next,
  output logic                 q_bit
);

  // Keep the full partial remainder in the trial value so the compare has
  // headroom. The top bit of pr is always zero between steps, which makes this
  // equivalent to {pr[DIVISOR_W-1:0], dividend_bit}.
  logic [DIVISOR_W+1:0] t;
  logic [DIVISOR_W+1:0] d_ext;

  assign t     = {pr, dividend_bit};
  assign d_ext = {2'b00, divisor};
  assign q_bit = (t >= d_ext);

  // Restore (keep t) when the divisor does not fit; the difference always fits
  // in DIVISOR_W+1 bits because it is smaller than the divisor.
  assign pr_next = q_bit ? (DIVISOR_W+1)'(t - d_ext) : t[DIVISOR_W:0];

endmodule

// File: rtl/divide_restoring.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, with
// valid/ready handshakes on both the operand and the result side.
module divide_restoring #(
  parameter int DIVIDEND_W = div_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = div_pkg::DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero
);

  import div_pkg::*;

  localparam int CW = $clog2(DIVIDEND_W);

  state_t                state;
  logic [DIVIDEND_W-1:0] dq;         // dividend shifting out, quotient shifting in
  logic [DIVISOR_W-1:0]  divisor_q;
  logic [DIVISOR_W:0]    pr;         // partial remainder, one bit wider than divisor
  logic [CW-1:0]         cnt;

  logic [DIVISOR_W:0]    pr_next;
  logic                  q_bit;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .pr           (pr),
    .dividend_bit (dq[DIVIDEND_W-1]),
    .divisor      (divisor_q),
    .pr_next      (pr_next),
    .q_bit        (q_bit)
  );

  // Handshake flags decode straight from the state register, so no input
  // reaches an output combinationally.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Control FSM, iteration counter and datapath registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dq        <= '0;
      divisor_q <= '0;
      pr        <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dq        <= dividend;
            divisor_q <= divisor;
            pr        <= '0;
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend[DIVISOR_W-1:0];
              div_zero  <= 1'b1;
              state     <= DONE;
            end else begin
              cnt   <= CW'(DIVIDEND_W - 1);
              state <= CALC;
            end
          end
        end

        CALC: begin
          dq  <= {dq[DIVIDEND_W-2:0], q_bit};
          pr  <= pr_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            // Capture the final step straight into the result registers so
            // they stay untouched while the next job runs.
            quotient  <= {dq[DIVIDEND_W-2:0], q_bit};
            remainder <= pr_next[DIVISOR_W-1:0];
            div_zero  <= 1'b0;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) state <= IDLE;
        end

        // NOTE: a default arm returns any unencoded state value to IDLE and
        // keeps the case complete, so no latch-like hold is implied.
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/divide_restoring.md
# divide_restoring

Sequential unsigned restoring divider, the inverse companion of the subarray 8x8 CSA multiplier. It accepts a 16-bit dividend and an 8-bit divisor through a valid/ready handshake and retires one quotient bit per cycle. It returns a 16-bit quotient and an 8-bit remainder through a second valid/ready handshake. It sits in SUBARRAY_MAC beside the multiplier for scaling and normalisation of MAC results.

## Interface
- DIVIDEND_W, 16, dividend and quotient width
- DIVISOR_W, 8, divisor and remainder width
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- dividend  input  DIVIDEND_W  unsigned dividend
- divisor  input  DIVISOR_W  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  DIVIDEND_W  unsigned quotient
- remainder  output  DIVISOR_W  unsigned remainder
- div_zero  output  1  divisor was zero for this result

## Operation
- The FSM has three states: IDLE, CALC and DONE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - On in_valid, latch dividend into the shift register dq, latch divisor, and clear the partial remainder pr (DIVISOR_W+1 bits).
  - If divisor==0, go to DONE with quotient all ones, remainder=dividend[DIVISOR_W-1:0] and div_zero=1.
  - Otherwise load the iteration counter with DIVIDEND_W-1 and go to CALC.
- **CALC** performs one step per cycle:
  - t = {pr[DIVISOR_W-1:0], dq[MSB]}.
  - If t >= {1'b0, divisor}: pr = t - divisor, and shift 1 into dq[0].
  - Else: pr = t, and shift 0 into dq[0].
  - dq shifts left by one each step.
  - When the counter reaches 0 (DIVIDEND_W steps total), go to DONE.
- **DONE**
  - out_valid=1; quotient=dq and remainder=pr[DIVISOR_W-1:0] are held stable.
  - On out_ready, go to IDLE. Outputs keep their last value; only out_valid drops.
- in_ready is 0 in CALC and DONE. Operands presented then are ignored, not queued.
- in_valid is sampled only in IDLE. in_valid and dividend/divisor need not stay stable after acceptance.
- Arithmetic rules:
  - Fully unsigned.
  - The partial remainder is one bit wider than the divisor, so the comparison never overflows.
  - The invariant quotient*divisor + remainder == dividend, with remainder < divisor, must hold for every divisor != 0.
- Reset mid-operation abandons the division: next cycle is IDLE with no output.
- **Reset values:** in_ready=1, out_valid=0, quotient=0, remainder=0, div_zero=0, counter=0, state IDLE.

## Timing
- Acceptance is cycle 0 (in_valid & in_ready).
- Normal divisor: CALC occupies cycles 1..16 and out_valid rises in cycle 17. Latency is DIVIDEND_W+1 cycles.
- Divisor 0: out_valid in cycle 1.
- The result handshake completes in the cycle with out_valid & out_ready. in_ready returns in the following cycle.
- Minimum initiation interval is DIVIDEND_W+2 cycles (one cycle in IDLE between jobs).
- If out_ready is held high throughout, DONE lasts exactly one cycle.
- Backpressure (out_ready=0) holds DONE indefinitely with all outputs unchanged.
- No combinational path from any input to any output. in_ready and out_valid are decoded from registered state only.

## Structure
- Package div_pkg holds:
  - the state enum {IDLE, CALC, DONE};
  - the default widths DIVIDEND_W and DIVISOR_W;
  - the counter width $clog2(DIVIDEND_W).
- Sub-module div_step: a combinational single restoring step.
  - Inputs: pr, next dividend bit, divisor.
  - Outputs: next pr and quotient bit.
  - Instantiated once. The FSM, counter and registers live in divide_restoring.

## Test plan
- dividend=1000, divisor=7: quotient=142 (0x008E), remainder=6, div_zero=0, out_valid in cycle 17.
- dividend=0xFFFF, divisor=0xFF: quotient=0x0101, remainder=0x00. dividend=0x0000, divisor=5: quotient=0, remainder=0.
- Inverse of multiplier: dividend=2600 (200*13), divisor=13: quotient=200, remainder=0.
  - Also run random a, b != 0 through the CSA multiplier and back; require quotient=a, remainder=0.
- dividend=0x1234, divisor=0: out_valid in cycle 1, quotient=0xFFFF, remainder=0x34, div_zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - Outputs stay stable and in_ready stays 0.
  - in_valid pulsed with new operands during CALC/DONE is ignored.
  - After out_ready, in_ready=1 in the next cycle.
- Assert rst in cycle 8 of CALC:
  - next cycle in_ready=1, out_valid=0, quotient=0, remainder=0;
  - a new division 50/3 then returns 16, remainder 2.
